// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between two byte sources.
// One granted byte is buffered; an owner lock keeps bursts contiguous up to MAX_BURST bytes.
module uart_tx_arbiter #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned MAX_BURST  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_req0_valid,
    input  logic [DATA_WIDTH-1:0] i_req0_data,
    input  logic                  i_req0_lock,
    output logic                  o_req0_ready,
    input  logic                  i_req1_valid,
    input  logic [DATA_WIDTH-1:0] i_req1_data,
    input  logic                  i_req1_lock,
    output logic                  o_req1_ready,
    output logic [DATA_WIDTH-1:0] o_tx_data,
    output logic                  o_tx_valid,
    input  logic                  i_tx_ready,
    output logic                  o_grant_id,
    output logic                  o_busy
);

    localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_hold_data;
    logic                  r_owner;
    logic                  r_last_grant;
    logic [CNT_W-1:0]      r_burst_cnt;
    logic                  r_tx_valid;
    logic                  r_busy;

    logic                  w_win;
    logic                  w_acc0;
    logic                  w_acc1;
    logic                  w_acc;
    logic [DATA_WIDTH-1:0] w_acc_data;
    logic                  w_own_lock;
    logic [CNT_W-1:0]      w_cnt_next;
    logic                  w_keep;

    // IDLE winner: a lone requester wins, a tie goes to the one not served last
    assign w_win = i_req1_valid & (~i_req0_valid | ~r_last_grant);

    // Ready is gated by rst_n so nothing is accepted while reset is held
    assign w_acc0 = rst_n & i_req0_valid &
                    (((r_state == ST_IDLE) & ~w_win) | ((r_state == ST_HOLD) & ~r_owner));
    assign w_acc1 = rst_n & i_req1_valid &
                    (((r_state == ST_IDLE) & w_win) | ((r_state == ST_HOLD) & r_owner));
    assign w_acc      = w_acc0 | w_acc1;
    assign w_acc_data = w_acc1 ? i_req1_data : i_req0_data;

    assign w_own_lock = r_owner ? i_req1_lock : i_req0_lock;
    assign w_cnt_next = r_burst_cnt + CNT_W'(1);
    assign w_keep     = w_own_lock & (w_cnt_next < CNT_W'(MAX_BURST));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_hold_data  <= '0;
            r_owner      <= 1'b0;
            r_last_grant <= 1'b1;
            r_burst_cnt  <= '0;
            r_tx_valid   <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_acc) begin
                        r_hold_data <= w_acc_data;
                        r_owner     <= w_acc1;
                        r_burst_cnt <= '0;
                        r_tx_valid  <= 1'b1;
                        r_busy      <= 1'b1;
                        r_state     <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (i_tx_ready) begin
                        r_burst_cnt <= w_cnt_next;
                        r_tx_valid  <= 1'b0;
                        if (w_keep) begin
                            r_state <= ST_HOLD;
                        end else begin
                            r_last_grant <= r_owner;
                            r_busy       <= 1'b0;
                            r_state      <= ST_IDLE;
                        end
                    end
                end
                ST_HOLD: begin
                    // A new byte from the owner outranks a lock drop in the same cycle
                    if (w_acc) begin
                        r_hold_data <= w_acc_data;
                        r_tx_valid  <= 1'b1;
                        r_state     <= ST_SEND;
                    end else if (!w_own_lock) begin
                        r_last_grant <= r_owner;
                        r_busy       <= 1'b0;
                        r_state      <= ST_IDLE;
                    end
                end
                default: begin
                    r_tx_valid <= 1'b0;
                    r_busy     <= 1'b0;
                    r_state    <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_req0_ready = w_acc0;
    assign o_req1_ready = w_acc1;
    assign o_tx_data    = r_hold_data;
    assign o_tx_valid   = r_tx_valid;
    assign o_grant_id   = r_owner;
    assign o_busy       = r_busy;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: directed timing scenarios plus randomized
// message streams whose transmit order comes from a message-level arbitration model.
module tb_uart_tx_arbiter;

    localparam int MB = 4;

    typedef struct packed {
        logic [7:0] d;
        logic       l;
    } byte_t;

    typedef struct packed {
        logic [7:0] d;
        logic       id;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       v0 = 1'b0, l0 = 1'b0, v1 = 1'b0, l1 = 1'b0, tx_ready = 1'b0;
    logic [7:0] d0 = 8'h00, d1 = 8'h00;
    logic       r0, r1, txv, gid, busy;
    logic [7:0] txd;

    int    n_tests = 0;
    int    n_fail  = 0;
    exp_t  sb[$];
    byte_t m0[$];
    byte_t m1[$];

    uart_tx_arbiter #(.DATA_WIDTH(8), .MAX_BURST(MB)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_req0_valid (v0),
        .i_req0_data  (d0),
        .i_req0_lock  (l0),
        .o_req0_ready (r0),
        .i_req1_valid (v1),
        .i_req1_data  (d1),
        .i_req1_lock  (l1),
        .o_req1_ready (r1),
        .o_tx_data    (txd),
        .o_tx_valid   (txv),
        .i_tx_ready   (tx_ready),
        .o_grant_id   (gid),
        .o_busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every transmitter handshake is checked against the scoreboard head
    always @(negedge clk) begin
        if (rst_n) begin
            chk("ready_exclusive", 32'(r0 & r1), 32'd0);
            if (txv && tx_ready) begin
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL tx_unexpected: got byte 0x%0h id %0d, expected no byte", txd, gid);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("tx_data", 32'(txd), 32'(e.d));
                    chk("tx_owner", 32'(gid), 32'(e.id));
                end
            end
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        v0 = 1'b0; v1 = 1'b0; l0 = 1'b0; l1 = 1'b0; tx_ready = 1'b0;
        d0 = 8'h00; d1 = 8'h00;
        cyc();
        chk("rst_tx_valid", 32'(txv), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_grant_id", 32'(gid), 32'd0);
        chk("rst_tx_data", 32'(txd), 32'd0);
        cyc();
        rst_n = 1'b1;
        sb.delete();
    endtask

    task automatic add_msg(input bit who, input int len, input logic [7:0] base, input bit rnd);
        for (int i = 0; i < len; i++) begin
            byte_t b;
            b.d = rnd ? 8'($urandom) : base + 8'(i);
            b.l = (i != len - 1);
            if (who) m1.push_back(b);
            else     m0.push_back(b);
        end
    endtask

    // Message-level reference: round-robin grants, locked runs capped at MB bytes
    task automatic model();
        int   i0 = 0;
        int   i1 = 0;
        logic last = 1'b1;
        while (i0 < m0.size() || i1 < m1.size()) begin
            logic own;
            int   cnt;
            bit   keep;
            if (i0 >= m0.size())      own = 1'b1;
            else if (i1 >= m1.size()) own = 1'b0;
            else                      own = ~last;
            cnt = 0;
            keep = 1'b1;
            while (keep) begin
                byte_t b;
                if (own) begin b = m1[i1]; i1++; end
                else     begin b = m0[i0]; i0++; end
                sb.push_back('{d: b.d, id: own});
                cnt++;
                keep = b.l && (cnt < MB);
            end
            last = own;
        end
    endtask

    // Sources stream their bytes back-to-back; lock follows the last accepted byte
    task automatic run_stream(input string nm, input bit rnd, input int maxcyc);
        int   idx0 = 0, idx1 = 0, c = 0, n;
        logic lk0 = 1'b0, lk1 = 1'b0, a0, a1;
        bit   done = 1'b0;
        model();
        n = sb.size();
        while (!done && c < maxcyc) begin
            v0 = (idx0 < m0.size());
            d0 = v0 ? m0[idx0].d : 8'h00;
            l0 = lk0;
            v1 = (idx1 < m1.size());
            d1 = v1 ? m1[idx1].d : 8'h00;
            l1 = lk1;
            tx_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            a0 = v0 & r0;
            a1 = v1 & r1;
            cyc();
            c++;
            if (a0) begin lk0 = m0[idx0].l; idx0++; end
            if (a1) begin lk1 = m1[idx1].l; idx1++; end
            done = (idx0 == m0.size()) && (idx1 == m1.size()) && (sb.size() == 0) && !txv;
        end
        chk({nm, "_complete"}, 32'(done), 32'd1);
        if (!rnd) chk({nm, "_cycles"}, 32'(c), 32'(2 * n));
        m0.delete();
        m1.delete();
        v0 = 1'b0; v1 = 1'b0; l0 = 1'b0; l1 = 1'b0; tx_ready = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();

        // Reset asserted mid-SEND drops the byte; req1 is taken on the first edge after release
        v0 = 1'b1; d0 = 8'h33; tx_ready = 1'b0;
        cyc();
        v0 = 1'b0;
        #1;
        chk("send_tx_valid", 32'(txv), 32'd1);
        chk("send_busy", 32'(busy), 32'd1);
        v1 = 1'b1; d1 = 8'h41;
        #1;
        chk("send_r1_blocked", 32'(r1), 32'd0);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_tx_valid", 32'(txv), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_r0", 32'(r0), 32'd0);
        chk("arst_r1", 32'(r1), 32'd0);
        chk("arst_grant_id", 32'(gid), 32'd0);
        cyc();
        cyc();
        rst_n = 1'b1;
        #1;
        chk("post_rst_r1", 32'(r1), 32'd1);
        sb.push_back('{d: 8'h41, id: 1'b1});
        cyc();
        v1 = 1'b0;
        #1;
        chk("post_rst_tx_valid", 32'(txv), 32'd1);
        tx_ready = 1'b1;
        cyc();
        tx_ready = 1'b0;
        #1;
        chk("post_rst_idle", 32'(busy), 32'd0);

        // Single transfer held by back-pressure for three cycles
        v0 = 1'b1; d0 = 8'h55;
        cyc();
        v0 = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("hold_tx_valid", 32'(txv), 32'd1);
            chk("hold_tx_data", 32'(txd), 32'h55);
            cyc();
        end
        tx_ready = 1'b1;
        sb.push_back('{d: 8'h55, id: 1'b0});
        #1;
        chk("hold_tx_valid4", 32'(txv), 32'd1);
        chk("hold_tx_data4", 32'(txd), 32'h55);
        cyc();
        tx_ready = 1'b0;
        #1;
        chk("single_busy_drop", 32'(busy), 32'd0);
        chk("single_valid_drop", 32'(txv), 32'd0);

        // HOLD keeps the grant while the owner idles with lock set
        v0 = 1'b1; d0 = 8'hA5; l0 = 1'b1;
        cyc();
        v0 = 1'b0;
        v1 = 1'b1; d1 = 8'h5A;
        tx_ready = 1'b1;
        sb.push_back('{d: 8'hA5, id: 1'b0});
        cyc();
        tx_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("hold_busy", 32'(busy), 32'd1);
            chk("hold_r1_blocked", 32'(r1), 32'd0);
            cyc();
        end
        l0 = 1'b0;
        #1;
        chk("hold_release_wait", 32'(r1), 32'd0);
        cyc();
        #1;
        chk("hold_release_idle", 32'(busy), 32'd0);
        chk("hold_release_r1", 32'(r1), 32'd1);
        sb.push_back('{d: 8'h5A, id: 1'b1});
        cyc();
        v1 = 1'b0;
        tx_ready = 1'b1;
        cyc();
        tx_ready = 1'b0;
        chk("hold_sb_drained", 32'(sb.size()), 32'd0);

        // Fair tie: four single-byte messages per requester, full-rate transmitter
        do_reset();
        for (int i = 0; i < 4; i++) begin
            add_msg(1'b0, 1, 8'h20 + 8'(i), 1'b0);
            add_msg(1'b1, 1, 8'h30 + 8'(i), 1'b0);
        end
        run_stream("tie", 1'b0, 200);

        // Locked burst from req1 is not broken up by the waiting req0
        do_reset();
        add_msg(1'b0, 1, 8'h20, 1'b0);
        add_msg(1'b0, 1, 8'h21, 1'b0);
        add_msg(1'b1, 4, 8'h10, 1'b0);
        run_stream("locked", 1'b0, 200);

        // Burst cap: a 6-byte locked message is split after MB bytes
        do_reset();
        add_msg(1'b0, 6, 8'h60, 1'b0);
        add_msg(1'b1, 1, 8'h99, 1'b0);
        run_stream("cap", 1'b0, 200);

        // Randomized messages with random transmitter back-pressure
        for (int t = 0; t < 8; t++) begin
            do_reset();
            for (int k = 0; k < int'($urandom_range(0, 3)); k++)
                add_msg(1'b0, int'($urandom_range(1, 6)), 8'h00, 1'b1);
            for (int k = 0; k < int'($urandom_range(0, 3)); k++)
                add_msg(1'b1, int'($urandom_range(1, 6)), 8'h00, 1'b1);
            run_stream("random", 1'b1, 2000);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
